// File: rtl/uart_pkg.sv
// Shared encodings for the UART echo FIFO controller: transform modes,
// RX/TX FSM states and the TX busy-detect timeout.
package uart_pkg;
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ECHO    = 2'd0;
    localparam mode_t MODE_XOR     = 2'd1;
    localparam mode_t MODE_REV     = 2'd2;
    localparam mode_t MODE_DISCARD = 2'd3;

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_ACK  = 2'd1;
    localparam logic [1:0] RX_DROP = 2'd2;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_LOAD = 2'd1;
    localparam logic [1:0] TX_BUSY = 2'd2;
    localparam logic [1:0] TX_WAIT = 2'd3;

    // Cycles to wait in TX_BUSY for a late-starting transmitter before
    // treating the word as sent.
    localparam int TX_TIMEOUT = 4;
endpackage

// File: rtl/uart_echo_fifo_ctrl_sync_fifo.sv
// Synchronous FIFO with a registered occupancy count. A write while full is
// dropped even if a pop happens in the same cycle.
module sync_fifo #(
    parameter  int DATA_LEN   = 8,
    parameter  int FIFO_DEPTH = 16,
    localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                rd_en,
    output logic [DATA_LEN-1:0] rd_data,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                empty
);
    localparam int            CW      = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DATA_LEN-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                w_wr_acc;
    logic                w_rd_acc;

    assign full     = (r_count == DEPTH_C);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign rd_data  = r_mem[r_rd_ptr];
    assign w_wr_acc = wr_en & ~full;
    assign w_rd_acc = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
    end

    // Pointers are exactly ADDR_W wide, so wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/uart_echo_fifo_ctrl.sv
// UART echo controller: acks received words into a FIFO (with an optional
// per-word transform) and replays them to the transmitter back-to-back.
module uart_echo_fifo_ctrl
    import uart_pkg::*;
#(
    parameter  int DATA_LEN   = 8,
    parameter  int FIFO_DEPTH = 16,
    localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_data_ready,
    input  logic [DATA_LEN-1:0] rx_data,
    output logic                rx_data_readed,
    input  logic                tx_empty,
    output logic [DATA_LEN-1:0] tx_data,
    output logic                tx_load,
    input  logic [1:0]          mode,
    input  logic [DATA_LEN-1:0] xor_mask,
    input  logic                clear_overflow,
    output logic [ADDR_W:0]     fifo_count,
    output logic                overflow
);
    localparam int TO_W = $clog2(TX_TIMEOUT);

    logic [1:0]          r_rx_state;
    logic [1:0]          r_tx_state;
    logic [TO_W-1:0]     r_to_cnt;
    logic [DATA_LEN-1:0] r_tx_data;
    logic                r_overflow;

    logic [DATA_LEN-1:0] w_rev;
    logic [DATA_LEN-1:0] w_xf;
    logic [DATA_LEN-1:0] w_head;
    logic                w_wr_en;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    mode_t               w_mode;

    assign w_mode = mode_t'(mode);

    for (genvar i = 0; i < DATA_LEN; i++) begin : g_rev
        assign w_rev[i] = rx_data[DATA_LEN-1-i];
    end

    always_comb begin
        w_xf = rx_data;
        case (w_mode)
            MODE_XOR: w_xf = rx_data ^ xor_mask;
            MODE_REV: w_xf = w_rev;
            default:  w_xf = rx_data;
        endcase
    end

    // Transform and mode are sampled in the single ack cycle.
    assign w_wr_en = (r_rx_state == RX_ACK) && (w_mode != MODE_DISCARD);
    assign w_pop   = (r_tx_state == TX_IDLE) && !w_empty && tx_empty;

    sync_fifo #(
        .DATA_LEN  (DATA_LEN),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (w_wr_en),
        .wr_data(w_xf),
        .rd_en  (w_pop),
        .rd_data(w_head),
        .count  (fifo_count),
        .full   (w_full),
        .empty  (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
        end else begin
            case (r_rx_state)
                RX_IDLE: if (rx_data_ready) r_rx_state <= RX_ACK;
                RX_ACK:  r_rx_state <= RX_DROP;
                RX_DROP: if (!rx_data_ready) r_rx_state <= RX_IDLE;
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // A set in the same cycle as clear_overflow wins.
    always_ff @(posedge clk) begin
        if (rst)                     r_overflow <= 1'b0;
        else if (w_wr_en && w_full)  r_overflow <= 1'b1;
        else if (clear_overflow)     r_overflow <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_data  <= '0;
            r_to_cnt   <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= w_head;
                        r_tx_state <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    r_to_cnt   <= '0;
                    r_tx_state <= TX_BUSY;
                end
                TX_BUSY: begin
                    // Some cores never drop tx_empty for short words; give up
                    // waiting and count the word as sent.
                    if (!tx_empty)                             r_tx_state <= TX_WAIT;
                    else if (r_to_cnt == TO_W'(TX_TIMEOUT-1))  r_tx_state <= TX_IDLE;
                    else                                       r_to_cnt   <= r_to_cnt + TO_W'(1);
                end
                TX_WAIT: if (tx_empty) r_tx_state <= TX_IDLE;
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign rx_data_readed = (r_rx_state == RX_ACK);
    assign tx_load        = (r_tx_state == TX_LOAD);
    assign tx_data        = r_tx_data;
    assign overflow       = r_overflow;
endmodule

// File: tb/tb_uart_echo_fifo_ctrl.sv
// Scoreboard bench: the RX driver pushes expected words at ack time; an
// independent monitor pops and compares on every tx_load.
module tb_uart_echo_fifo_ctrl;
    localparam int DL    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_data_ready = 1'b0;
    logic [DL-1:0] rx_data = '0;
    logic          rx_data_readed;
    logic          tx_empty = 1'b1;
    logic [DL-1:0] tx_data;
    logic          tx_load;
    logic [1:0]    mode = 2'd0;
    logic [DL-1:0] xor_mask = '0;
    logic          clear_overflow = 1'b0;
    logic [4:0]    fifo_count;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ack = 0;
    int n_load = 0;
    logic [DL-1:0] exp_q[$];
    bit exp_ovf = 1'b0;

    bit tx_hold  = 1'b0;
    bit tx_never = 1'b0;
    int tx_busy  = 3;

    uart_echo_fifo_ctrl #(.DATA_LEN(DL), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_ready (rx_data_ready),
        .rx_data       (rx_data),
        .rx_data_readed(rx_data_readed),
        .tx_empty      (tx_empty),
        .tx_data       (tx_data),
        .tx_load       (tx_load),
        .mode          (mode),
        .xor_mask      (xor_mask),
        .clear_overflow(clear_overflow),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DL-1:0] model_xf(input logic [DL-1:0] w, input logic [1:0] m,
                                               input logic [DL-1:0] k);
        logic [DL-1:0] r;
        case (m)
            2'd1:    r = w ^ k;
            2'd2:    r = {<<{w}};
            default: r = w;
        endcase
        return r;
    endfunction

    // Transmitter model: goes busy for tx_busy cycles after each load,
    // unless held busy or configured never to go busy.
    initial forever begin
        @(negedge clk);
        if (tx_hold) tx_empty = 1'b0;
        else if (tx_load && !tx_never) begin
            tx_empty = 1'b0;
            repeat (tx_busy) @(negedge clk);
            tx_empty = 1'b1;
        end else tx_empty = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (rx_data_readed) n_ack++;
        if (tx_load) begin
            n_load++;
            if (exp_q.size() == 0) chk("unexpected_load", 1, 0);
            else chk("tx_data", int'(tx_data), int'(exp_q.pop_front()));
        end
    end

    // Present one word and hold ready for 'extra' cycles after the ack.
    task automatic send(input logic [DL-1:0] w, input int extra);
        int t;
        @(negedge clk);
        rx_data = w;
        rx_data_ready = 1'b1;
        t = 0;
        while (!rx_data_readed && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ack_timeout", 0, 1);
        else if (mode != 2'd3) begin
            // Stored words equal the pending queue whenever the FIFO can fill.
            if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back(model_xf(w, mode, xor_mask));
        end
        repeat (extra) @(negedge clk);
        rx_data_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || fifo_count != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int a0, l0;
        repeat (3) @(negedge clk);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_load", tx_load, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rx_readed", rx_data_readed, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single echo with exact latency.
        rx_data = 8'h41;
        rx_data_ready = 1'b1;
        exp_q.push_back(8'h41);
        @(negedge clk);
        chk("echo_ack", rx_data_readed, 1);
        rx_data_ready = 1'b0;
        @(negedge clk);
        chk("echo_count", fifo_count, 1);
        @(negedge clk);
        chk("echo_latency_load", tx_load, 1);
        repeat (10) @(negedge clk);
        chk("echo_count_after", fifo_count, 0);

        // Transforms.
        mode = 2'd1; xor_mask = 8'h20;
        send(8'h61, 0);
        mode = 2'd2;
        send(8'h01, 0);
        drain();
        mode = 2'd3;
        a0 = n_ack; l0 = n_load;
        send(8'h55, 0);
        repeat (10) @(negedge clk);
        chk("discard_ack", n_ack - a0, 1);
        chk("discard_noload", n_load - l0, 0);
        chk("discard_count", fifo_count, 0);

        // Burst into a stalled transmitter, then overflow.
        mode = 2'd0;
        tx_hold = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) send(DL'(i), 0);
        chk("burst_count", fifo_count, DEPTH);
        chk("burst_no_ovf", overflow, 0);
        send(8'hAA, 0);
        chk("ovf_set", overflow, int'(exp_ovf));
        chk("ovf_count", fifo_count, DEPTH);
        tx_hold = 1'b0;
        drain();
        chk("ovf_sticky", overflow, 1);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        exp_ovf = 1'b0;
        chk("ovf_cleared", overflow, int'(exp_ovf));

        // Concurrent RX every ~10 cycles, TX ~25 cycles per word.
        tx_busy = 25;
        a0 = n_ack;
        for (int i = 0; i < 20; i++) begin
            send(DL'($urandom), 0);
            repeat (6) @(negedge clk);
        end
        chk("conc_no_ovf", overflow, int'(exp_ovf));
        drain();
        chk("conc_acks", n_ack - a0, 20);

        // Randomised modes, masks, data and handshake lengths.
        tx_busy = 2;
        for (int i = 0; i < 40; i++) begin
            mode = 2'($urandom_range(0, 3));
            xor_mask = DL'($urandom);
            send(DL'($urandom), $urandom_range(0, 3));
        end
        drain();
        chk("rand_no_ovf", overflow, 0);

        // Slow handshake plus a transmitter that never reports busy.
        mode = 2'd0;
        tx_never = 1'b1;
        a0 = n_ack; l0 = n_load;
        send(8'h11, 3);
        send(8'h22, 3);
        send(8'h33, 3);
        drain();
        chk("slow_acks", n_ack - a0, 3);
        chk("never_busy_loads", n_load - l0, 3);
        tx_never = 1'b0;

        // Reset while the transmitter is busy on the first of five words.
        tx_busy = 30;
        for (int i = 0; i < 5; i++) send(DL'(8'hC0 + i), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_load", tx_load, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        exp_q.delete();
        rst = 1'b0;
        l0 = n_load;
        repeat (100) @(negedge clk);
        chk("post_rst_loads", n_load - l0, 0);
        chk("post_rst_count", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
